// File: rtl/signal_pkg.sv
// Shared phase codes and duration helpers for the intersection signal controllers.
package signal_pkg;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Longest of the three phase durations; sizes the shared phase timer.
  function automatic int max_dur(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rr_next_road.sv
// Round-robin picker: first demanding road after cur_road, with cur_road itself checked last.
// Purely combinational; no flow control.
module rr_next_road #(
  parameter int NUM_ROADS  = 3,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic [NUM_ROADS-1:0]         demand,
  input  logic [$clog2(NUM_ROADS)-1:0] cur_road,
  output logic [$clog2(NUM_ROADS)-1:0] next_road,
  output logic                         found
);

  localparam int RW = $clog2(NUM_ROADS);

  logic [2*NUM_ROADS-1:0] dbl;
  logic [NUM_ROADS-1:0]   rot;
  logic [RW:0]            start;
  logic [RW:0]            off;
  logic [RW:0]            sum;

  // Rotate demand so bit k is road (cur_road+1+k) mod NUM_ROADS; the extra bit keeps cur_road+1 from wrapping.
  assign dbl   = {demand, demand};
  assign start = {1'b0, cur_road} + (RW+1)'(1);
  assign rot   = NUM_ROADS'(dbl >> start);

  always_comb begin
    off   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = NUM_ROADS-1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = (RW+1)'(k);
        found = 1'b1;
      end
    end
    if (!SKIP_EMPTY) begin
      off   = '0;
      found = 1'b1;
    end
    sum = start + off;
    if (sum >= (RW+1)'(NUM_ROADS)) sum = sum - (RW+1)'(NUM_ROADS);
    next_road = sum[RW-1:0];
  end

endmodule

// File: rtl/multi_road_signal_ctrl.sv
// N-road signal sequencer: ALL_RED -> GREEN -> YELLOW round-robin, skipping roads without demand.
// All outputs registered and change on the state edge; enable=0 freezes timer, state and lamps.
module multi_road_signal_ctrl
  import signal_pkg::*;
#(
  parameter int NUM_ROADS  = 3,
  parameter int GREEN_CYC  = 6,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_ROADS-1:0]         car_present,
  output logic [NUM_ROADS-1:0]         red,
  output logic [NUM_ROADS-1:0]         yellow,
  output logic [NUM_ROADS-1:0]         green,
  output logic [$clog2(NUM_ROADS)-1:0] active_road,
  output logic [1:0]                   phase
);

  localparam int RW = $clog2(NUM_ROADS);
  localparam int TW = $clog2(max_dur(GREEN_CYC, YELLOW_CYC, ALLRED_CYC)) + 1;

  localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_CYC - 1);

  phase_e          state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   next_road;
  logic            found;

  rr_next_road #(
    .NUM_ROADS  (NUM_ROADS),
    .SKIP_EMPTY (SKIP_EMPTY)
  ) u_pick (
    .demand    (car_present),
    .cur_road  (active_road),
    .next_road (next_road),
    .found     (found)
  );

  function automatic logic [NUM_ROADS-1:0] road_bit(input logic [RW-1:0] r);
    road_bit    = '0;
    road_bit[r] = 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= PH_ALL_RED;
      timer       <= T_ALLRED;
      active_road <= RW'(NUM_ROADS - 1);
      red         <= '1;
      yellow      <= '0;
      green       <= '0;
    end else if (enable) begin
      case (state)
        PH_ALL_RED: begin
          // With no demand the timer parks at zero and demand is re-polled every cycle.
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (found) begin
            state       <= PH_GREEN;
            timer       <= T_GREEN;
            active_road <= next_road;
            green       <= road_bit(next_road);
            red         <= ~road_bit(next_road);
          end
        end
        PH_GREEN: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            state  <= PH_YELLOW;
            timer  <= T_YELLOW;
            yellow <= green;
            green  <= '0;
          end
        end
        PH_YELLOW: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            state  <= PH_ALL_RED;
            timer  <= T_ALLRED;
            red    <= '1;
            yellow <= '0;
          end
        end
        default: begin
          state  <= PH_ALL_RED;
          timer  <= T_ALLRED;
          red    <= '1;
          yellow <= '0;
          green  <= '0;
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_multi_road_signal_ctrl.sv
// Bench for multi_road_signal_ctrl: directed stimulus pushes expected phase events, monitors score them.
// DUT a runs SKIP_EMPTY=1 through all scenarios; DUT b runs SKIP_EMPTY=0 with no demand.
module tb_multi_road_signal_ctrl;

  localparam logic [1:0] PA = 2'd0;
  localparam logic [1:0] PG = 2'd1;
  localparam logic [1:0] PY = 2'd2;

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] road;
    logic [2:0] r;
    logic [2:0] y;
    logic [2:0] g;
  } snap_t;

  typedef struct {
    logic [1:0] ph;
    logic [1:0] road;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reset_b = 1'b0;
  logic       enable = 1'b1;
  logic       enable_b = 1'b1;
  logic [2:0] car = 3'b000;
  logic [2:0] car_b = 3'b000;

  logic [2:0] red_a, yellow_a, green_a, red_b, yellow_b, green_b;
  logic [1:0] road_a, road_b, phase_a, phase_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  multi_road_signal_ctrl #(
    .NUM_ROADS(3), .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1), .SKIP_EMPTY(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .car_present(car),
    .red(red_a), .yellow(yellow_a), .green(green_a),
    .active_road(road_a), .phase(phase_a)
  );

  multi_road_signal_ctrl #(
    .NUM_ROADS(3), .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1), .SKIP_EMPTY(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_b), .enable(enable_b), .car_present(car_b),
    .red(red_b), .yellow(yellow_b), .green(green_b),
    .active_road(road_b), .phase(phase_b)
  );

  function automatic snap_t model(input logic [1:0] ph, input logic [1:0] road);
    snap_t      s;
    logic [2:0] lit;
    lit    = 3'b001 << road;
    s.ph   = ph;
    s.road = road;
    s.r    = 3'b111;
    s.y    = 3'b000;
    s.g    = 3'b000;
    if (ph == PG) begin
      s.g = lit;
      s.r = ~lit;
    end else if (ph == PY) begin
      s.y = lit;
      s.r = ~lit;
    end
    return s;
  endfunction

  task automatic ea(input logic [1:0] ph, input int road, input int gap);
    exp_t e;
    e.ph = ph; e.road = road[1:0]; e.gap = gap;
    qa.push_back(e);
  endtask

  task automatic eb(input logic [1:0] ph, input int road, input int gap);
    exp_t e;
    e.ph = ph; e.road = road[1:0]; e.gap = gap;
    qb.push_back(e);
  endtask

  task automatic lamp_check(input int id, input snap_t s);
    n_checks++;
    if ((s.r | s.y | s.g) == 3'b111 && (s.r & s.y) == 3'b000 &&
        (s.r & s.g) == 3'b000 && (s.y & s.g) == 3'b000)
      n_pass++;
    else
      $display("FAIL lamps dut%0d t=%0t got r=%b y=%b g=%b want one lamp per road", id, $time, s.r, s.y, s.g);
  endtask

  task automatic score(input int id, input snap_t act, input int gap);
    exp_t  e;
    snap_t want;
    if (id == 0) begin
      if (qa.size() == 0) return;
      e = qa.pop_front();
    end else begin
      if (qb.size() == 0) return;
      e = qb.pop_front();
    end
    want = model(e.ph, e.road);
    n_checks++;
    if (act === want)
      n_pass++;
    else
      $display("FAIL event dut%0d t=%0t got ph=%0d road=%0d r=%b y=%b g=%b want ph=%0d road=%0d r=%b y=%b g=%b",
               id, $time, act.ph, act.road, act.r, act.y, act.g, want.ph, want.road, want.r, want.y, want.g);
    if (e.gap >= 0) begin
      n_checks++;
      if (gap == e.gap)
        n_pass++;
      else
        $display("FAIL duration dut%0d t=%0t ph=%0d road=%0d got %0d cycles want %0d", id, $time, e.ph, e.road, gap, e.gap);
    end
  endtask

  task automatic wait_until(input longint t);
    if ($time < t) #(t - $time);
  endtask

  // Monitor a: samples 1 time unit after each falling clock edge or reset assertion.
  initial begin
    snap_t prev, cur;
    int    gap;
    prev = 'x;
    gap  = 0;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      gap++;
      if (!reset_n) gap = 0;
      cur = {phase_a, road_a, red_a, yellow_a, green_a};
      lamp_check(0, cur);
      if (cur !== prev) begin
        score(0, cur, gap);
        gap = 0;
      end
      prev = cur;
    end
  end

  initial begin
    snap_t prev, cur;
    int    gap;
    prev = 'x;
    gap  = 0;
    forever begin
      @(negedge clk or negedge reset_b);
      #1;
      gap++;
      if (!reset_b) gap = 0;
      cur = {phase_b, road_b, red_b, yellow_b, green_b};
      lamp_check(1, cur);
      if (cur !== prev) begin
        score(1, cur, gap);
        gap = 0;
      end
      prev = cur;
    end
  end

  initial begin
    car = 3'b111;
    ea(PA, 2, -1);
    eb(PA, 2, -1);
    // No demand and no skipping: plain 0,1,2,0 rotation with a 21-cycle period.
    eb(PG,0,1); eb(PY,0,4); eb(PA,0,2); eb(PG,1,1); eb(PY,1,4); eb(PA,1,2);
    eb(PG,2,1); eb(PY,2,4); eb(PA,2,2); eb(PG,0,1); eb(PY,0,4); eb(PA,0,2); eb(PG,1,1);
    // All roads demanding from reset.
    ea(PG,0,1); ea(PY,0,4); ea(PA,0,2); ea(PG,1,1); ea(PY,1,4); ea(PA,1,2);
    ea(PG,2,1); ea(PY,2,4); ea(PA,2,2); ea(PG,0,1); ea(PY,0,4); ea(PA,0,2);
    ea(PG,1,1); ea(PY,1,4); ea(PA,1,2); ea(PG,2,1); ea(PY,2,4);
    wait_until(32);
    reset_n = 1'b1;
    reset_b = 1'b1;

    // Wrap-around: road 2 green, then roads 0 and 1 only.
    wait_until(402);
    car = 3'b011;
    ea(PA,2,2); ea(PG,0,1); ea(PY,0,4); ea(PA,0,2); ea(PG,1,1); ea(PY,1,4); ea(PA,1,2); ea(PG,0,1);

    // Skipping: sole demand on road 2 is re-served after each clearance.
    wait_until(622);
    car = 3'b100;
    ea(PY,0,4); ea(PA,0,2); ea(PG,2,1); ea(PY,2,4); ea(PA,2,2); ea(PG,2,1); ea(PY,2,4);

    // No demand: parks in all-red until road 1 asks, then green on the next edge.
    wait_until(762);
    car = 3'b000;
    ea(PA,2,2);
    wait_until(902);
    car = 3'b010;
    ea(PG,1,11); ea(PY,1,4); ea(PA,1,2); ea(PG,1,1);

    // Enable low for 5 edges while green timer is 2.
    wait_until(992);
    enable = 1'b0;
    ea(PY,1,9); ea(PA,1,2); ea(PG,1,1); ea(PY,1,4);
    wait_until(1042);
    enable = 1'b1;

    // Reset asserted between edges during yellow.
    wait_until(1153);
    ea(PA,2,-1);
    reset_n = 1'b0;
    car = 3'b111;
    ea(PG,0,1); ea(PY,0,4); ea(PA,0,2); ea(PG,1,1);
    wait_until(1182);
    reset_n = 1'b1;

    wait_until(1320);
    n_checks++;
    if (qa.size() == 0) n_pass++;
    else $display("FAIL drain_a got %0d events never seen want 0", qa.size());
    n_checks++;
    if (qb.size() == 0) n_pass++;
    else $display("FAIL drain_b got %0d events never seen want 0", qb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
